// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Brings up the on-chip PLL from its reference-clock domain and gates the
// downstream system reset. After reset the PLL is held powered down for
// PD_CYCLES, then released. The block waits for a (synchronized) LOCK,
// requires LOCK_STABLE_CYCLES consecutive locked cycles, and then releases
// SYS_RST. A lock drop in RUN re-asserts SYS_RST immediately and counts a
// loss event. Acquisition attempts that exceed LOCK_TIMEOUT_CYCLES are
// retried through a fresh power-down. After MAX_RETRIES failed attempts the
// block parks in a sticky FAULT state that only RST can clear.
//
// Ports
//   CLK        in   free-running PLL reference clock
//   RST        in   synchronous, active-high reset
//   PD_REQ     in   level, 1 = hold the PLL powered down (synchronous to CLK)
//   LOCK       in   PLL lock indication, asynchronous to CLK
//   POWERDOWN  out  to the PLL, active low (0 = PLL off)
//   SYS_RST    out  active-high reset for the PLL output clock domains
//   READY      out  1 only while in RUN
//   FAULT      out  sticky retry-exhaustion flag
//   RETRY_CNT  out  failed acquisitions since the last RUN/OFF
//   LOSS_CNT   out  lock-loss events seen in RUN, saturating at 255
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int PD_CYCLES           = 64,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PD_REQ,
    input  logic       LOCK,
    output logic       POWERDOWN,
    output logic       SYS_RST,
    output logic       READY,
    output logic       FAULT,
    output logic [1:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    // One shared cycle counter serves every timed state; it is sized for the
    // largest interval and restarted on each state entry.
    localparam int MAX_A     = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                               LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_PARAM = (MAX_A > PD_CYCLES) ? MAX_A : PD_CYCLES;
    localparam int CNT_W     = (MAX_PARAM > 1) ? $clog2(MAX_PARAM) : 1;

    localparam logic [CNT_W-1:0] PD_LAST      = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);
    localparam int               SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        S_PWRDN,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT,
        S_OFF
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         retry_q, retry_d;
    logic [7:0]         loss_q, loss_d;
    logic               powerdown_q, powerdown_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic               lock_s;

    // LOCK synchronizer: stage 0 samples the raw pin, later stages shift.
    assign sync_d[0] = LOCK;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        // A lock drop in RUN is a loss event even when PD_REQ wins the
        // state transition on the same cycle.
        if (state_q == S_RUN && !lock_s && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
        end

        if (state_q != S_FAULT) begin
            if (PD_REQ) begin
                state_d = S_OFF;
                cnt_d   = CNT_ZERO;
                retry_d = 2'd0;
            end else begin
                case (state_q)
                    S_PWRDN: begin
                        if (cnt_q >= PD_LAST) begin
                            state_d = S_WAIT_LOCK;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lock_s) begin
                            state_d = S_STABLE;
                            cnt_d   = CNT_ZERO;
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            retry_d = retry_q + 2'd1;
                            cnt_d   = CNT_ZERO;
                            state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_PWRDN;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    S_STABLE: begin
                        if (!lock_s) begin
                            state_d = S_WAIT_LOCK;
                            cnt_d   = CNT_ZERO;
                        end else if (cnt_q == STABLE_LAST) begin
                            state_d = S_RUN;
                            cnt_d   = CNT_ZERO;
                            retry_d = 2'd0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    S_RUN: begin
                        if (!lock_s) begin
                            state_d = S_WAIT_LOCK;
                            cnt_d   = CNT_ZERO;
                        end
                    end
                    S_OFF: begin
                        // The PLL has already been off for at least one
                        // cycle, so the exit edge counts as the first
                        // power-down cycle. POWERDOWN then rises PD_CYCLES
                        // edges after PD_REQ falls, as it does after reset.
                        state_d = S_PWRDN;
                        cnt_d   = CNT_ONE;
                    end
                    default: begin
                        state_d = S_PWRDN;
                        cnt_d   = CNT_ZERO;
                    end
                endcase
            end
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the state register.
        powerdown_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) ||
                      (state_d == S_RUN);
        sys_rst_d   = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_PWRDN;
            cnt_q       <= CNT_ZERO;
            retry_q     <= 2'd0;
            loss_q      <= 8'd0;
            powerdown_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            powerdown_q <= powerdown_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            sync_q      <= sync_d;
        end
    end

    assign POWERDOWN = powerdown_q;
    assign SYS_RST   = sys_rst_q;
    assign READY     = ready_q;
    assign FAULT     = fault_q;
    assign RETRY_CNT = retry_q;
    assign LOSS_CNT  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed scenarios for the bring-up, chatter, lock-loss, timeout, power-down
// and reset behaviour, followed by a randomized run compared cycle by cycle
// against a behavioural model of the supervisor's rules.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int LSC = 8;    // LOCK_STABLE_CYCLES
    localparam int LTO = 32;   // LOCK_TIMEOUT_CYCLES
    localparam int PDC = 4;    // PD_CYCLES
    localparam int MR  = 2;    // MAX_RETRIES

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pd_req = 1'b0;
    logic       lock = 1'b0;
    logic       powerdown, sys_rst, ready, fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTO),
        .PD_CYCLES          (PDC),
        .MAX_RETRIES        (MR)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .PD_REQ   (pd_req),
        .LOCK     (lock),
        .POWERDOWN(powerdown),
        .SYS_RST  (sys_rst),
        .READY    (ready),
        .FAULT    (fault),
        .RETRY_CNT(retry_cnt),
        .LOSS_CNT (loss_cnt)
    );

    // ------------------------------------------------------------------
    // Behavioural model: phases with "time spent in phase", lock seen
    // through a two-sample delay line.
    // ------------------------------------------------------------------
    typedef enum int {M_PWRDN, M_WAIT, M_STABLE, M_RUN, M_FAULT, M_OFF} mphase_t;
    mphase_t m_phase = M_PWRDN;
    int      m_t = 0;
    int      m_retry = 0;
    int      m_loss = 0;
    bit      m_s1 = 1'b0;
    bit      m_ls = 1'b0;
    bit      m_seen = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = M_PWRDN;
            m_t = 0; m_retry = 0; m_loss = 0;
            m_s1 = 1'b0; m_ls = 1'b0;
        end else begin
            m_seen = m_ls;
            m_ls   = m_s1;
            m_s1   = lock;
            if (m_phase != M_FAULT) begin
                if (m_phase == M_RUN && !m_seen && m_loss < 255) m_loss++;
                if (pd_req) begin
                    m_phase = M_OFF; m_t = 0; m_retry = 0;
                end else begin
                    case (m_phase)
                        M_PWRDN: begin
                            m_t++;
                            if (m_t >= PDC) begin m_phase = M_WAIT; m_t = 0; end
                        end
                        M_WAIT: begin
                            if (m_seen) begin
                                m_phase = M_STABLE; m_t = 0;
                            end else begin
                                m_t++;
                                if (m_t == LTO) begin
                                    m_retry++;
                                    m_t = 0;
                                    m_phase = (m_retry == MR) ? M_FAULT : M_PWRDN;
                                end
                            end
                        end
                        M_STABLE: begin
                            if (!m_seen) begin
                                m_phase = M_WAIT; m_t = 0;
                            end else begin
                                m_t++;
                                if (m_t == LSC) begin m_phase = M_RUN; m_t = 0; m_retry = 0; end
                            end
                        end
                        M_RUN: begin
                            if (!m_seen) begin m_phase = M_WAIT; m_t = 0; end
                        end
                        M_OFF: begin
                            m_phase = M_PWRDN; m_t = 1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // {POWERDOWN, SYS_RST, READY, FAULT, RETRY_CNT, LOSS_CNT} expected now
    function automatic logic [13:0] model_outputs();
        logic pd_e, sr_e, rd_e, ft_e;
        pd_e = (m_phase == M_WAIT) || (m_phase == M_STABLE) || (m_phase == M_RUN);
        sr_e = (m_phase != M_RUN);
        rd_e = (m_phase == M_RUN);
        ft_e = (m_phase == M_FAULT);
        return {pd_e, sr_e, rd_e, ft_e, 2'(m_retry), 8'(m_loss)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; pd_req = 1'b0; lock = 1'b0;
        tick(); tick();
        tests++; if (powerdown !== 1'b0) begin fails++; $display("FAIL reset_powerdown: got %b expected 0", powerdown); end
        tests++; if (sys_rst !== 1'b1) begin fails++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b expected 0", fault); end
        tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
        tests++; if (loss_cnt !== 8'd0) begin fails++; $display("FAIL reset_loss_cnt: got %0d expected 0", loss_cnt); end
        $display("[TB] reset: outputs at reset values checked");
    endtask

    task automatic test_nominal();
        int n;
        rst = 1'b1; lock = 1'b0; pd_req = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        while (powerdown !== 1'b1 && n < 50) begin tick(); n++; end
        tests++; if (n != PDC) begin fails++; $display("FAIL nominal_pd_rise_edges: got %0d expected %0d", n, PDC); end
        repeat (10) tick();
        lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        tests++; if (n != LSC + 3) begin fails++; $display("FAIL nominal_ready_edges: got %0d expected %0d", n, LSC + 3); end
        tests++; if (sys_rst !== 1'b0) begin fails++; $display("FAIL nominal_sys_rst: got %b expected 0", sys_rst); end
        tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL nominal_retry_cnt: got %0d expected 0", retry_cnt); end
        $display("[TB] nominal: POWERDOWN after %0d edges, READY after lock", PDC);
    endtask

    task automatic test_chatter();
        int n;
        bit early;
        rst = 1'b1; lock = 1'b0; pd_req = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        while (powerdown !== 1'b1 && n < 50) begin tick(); n++; end
        early = 1'b0;
        lock = 1'b1;
        repeat (5) begin tick(); if (ready === 1'b1) early = 1'b1; end
        lock = 1'b0;
        tick(); if (ready === 1'b1) early = 1'b1;
        lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        tests++; if (early) begin fails++; $display("FAIL chatter_early_run: got READY=1 expected 0 during chatter"); end
        tests++; if (n != LSC + 3) begin fails++; $display("FAIL chatter_ready_edges: got %0d expected %0d", n, LSC + 3); end
        tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL chatter_retry_cnt: got %0d expected 0", retry_cnt); end
        tests++; if (loss_cnt !== 8'd0) begin fails++; $display("FAIL chatter_loss_cnt: got %0d expected 0", loss_cnt); end
        $display("[TB] chatter: one-cycle drop restarted qualification");
    endtask

    task automatic test_lock_loss();
        int n;
        for (int k = 0; k < 2; k++) begin
            lock = 1'b0;
            n = 0;
            while (sys_rst !== 1'b1 && n < 20) begin tick(); n++; end
            tests++; if (n != 3) begin fails++; $display("FAIL loss_sys_rst_edges: got %0d expected 3", n); end
            tests++; if (ready !== 1'b0) begin fails++; $display("FAIL loss_ready: got %b expected 0", ready); end
            lock = 1'b1;
            n = 0;
            while (ready !== 1'b1 && n < 100) begin tick(); n++; end
            tests++; if (n != LSC + 3) begin fails++; $display("FAIL loss_relock_edges: got %0d expected %0d", n, LSC + 3); end
            $display("[TB] lock loss %0d: SYS_RST reasserted and RUN re-entered", k + 1);
        end
        tests++; if (loss_cnt !== 8'd2) begin fails++; $display("FAIL loss_cnt_two: got %0d expected 2", loss_cnt); end
        for (int k = 0; k < 298; k++) begin
            lock = 1'b0;
            n = 0;
            while (ready !== 1'b0 && n < 10) begin tick(); n++; end
            if (n >= 10) begin tests++; fails++; $display("FAIL loss_burst_drop_timeout: got READY=1 expected 0 at loss %0d", k); end
            lock = 1'b1;
            n = 0;
            while (ready !== 1'b1 && n < 30) begin tick(); n++; end
            if (n >= 30) begin tests++; fails++; $display("FAIL loss_burst_relock_timeout: got READY=0 expected 1 at loss %0d", k); end
        end
        tests++; if (loss_cnt !== 8'd255) begin fails++; $display("FAIL loss_cnt_saturate: got %0d expected 255", loss_cnt); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL loss_burst_run: got %b expected 1", ready); end
        $display("[TB] lock loss burst: 300 losses, LOSS_CNT=%0d", loss_cnt);
    endtask

    task automatic test_pd_req();
        int n;
        pd_req = 1'b1;
        tick();
        tests++; if (powerdown !== 1'b0) begin fails++; $display("FAIL pdreq_powerdown: got %b expected 0", powerdown); end
        tests++; if (sys_rst !== 1'b1) begin fails++; $display("FAIL pdreq_sys_rst: got %b expected 1", sys_rst); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL pdreq_ready: got %b expected 0", ready); end
        repeat (19) tick();
        pd_req = 1'b0;
        n = 0;
        while (powerdown !== 1'b1 && n < 50) begin tick(); n++; end
        tests++; if (n != PDC) begin fails++; $display("FAIL pdreq_release_edges: got %0d expected %0d", n, PDC); end
        tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL pdreq_retry_cnt: got %0d expected 0", retry_cnt); end
        n = 0;
        while (ready !== 1'b1 && n < 50) begin tick(); n++; end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL pdreq_rerun: got %b expected 1", ready); end
        $display("[TB] pd_req: 20-cycle power-down request served");
    endtask

    task automatic test_reset_mid_stable();
        int n;
        lock = 1'b0;
        n = 0;
        while (sys_rst !== 1'b1 && n < 20) begin tick(); n++; end
        tests++; if (loss_cnt !== 8'd255) begin fails++; $display("FAIL midstable_loss_hold: got %0d expected 255", loss_cnt); end
        lock = 1'b1;
        repeat (3 + 5) tick();
        tests++; if (powerdown !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL midstable_pre: got pd=%b rdy=%b expected pd=1 rdy=0", powerdown, ready); end
        rst = 1'b1;
        tick();
        tests++; if (powerdown !== 1'b0) begin fails++; $display("FAIL midstable_powerdown: got %b expected 0", powerdown); end
        tests++; if (sys_rst !== 1'b1) begin fails++; $display("FAIL midstable_sys_rst: got %b expected 1", sys_rst); end
        tests++; if (ready !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL midstable_ready_fault: got %b%b expected 00", ready, fault); end
        tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL midstable_retry_cnt: got %0d expected 0", retry_cnt); end
        tests++; if (loss_cnt !== 8'd0) begin fails++; $display("FAIL midstable_loss_cnt: got %0d expected 0", loss_cnt); end
        $display("[TB] reset mid-STABLE: reset values restored");
    endtask

    task automatic test_timeout();
        int n;
        rst = 1'b1; lock = 1'b0; pd_req = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        while (powerdown !== 1'b1 && n < 50) begin tick(); n++; end
        n = 0;
        while (powerdown !== 1'b0 && n < 100) begin tick(); n++; end
        tests++; if (n != LTO) begin fails++; $display("FAIL timeout1_edges: got %0d expected %0d", n, LTO); end
        tests++; if (retry_cnt !== 2'd1 || fault !== 1'b0) begin fails++; $display("FAIL timeout1_state: got retry=%0d fault=%b expected retry=1 fault=0", retry_cnt, fault); end
        n = 0;
        while (powerdown !== 1'b1 && n < 50) begin tick(); n++; end
        tests++; if (n != PDC) begin fails++; $display("FAIL timeout_pd_low: got %0d expected %0d", n, PDC); end
        n = 0;
        while (powerdown !== 1'b0 && n < 100) begin tick(); n++; end
        tests++; if (n != LTO) begin fails++; $display("FAIL timeout2_edges: got %0d expected %0d", n, LTO); end
        tests++; if (fault !== 1'b1) begin fails++; $display("FAIL timeout2_fault: got %b expected 1", fault); end
        tests++; if (retry_cnt !== 2'd2) begin fails++; $display("FAIL timeout2_retry_cnt: got %0d expected 2", retry_cnt); end
        tests++; if (sys_rst !== 1'b1) begin fails++; $display("FAIL timeout2_sys_rst: got %b expected 1", sys_rst); end
        lock = 1'b1; pd_req = 1'b1;
        repeat (10) tick();
        pd_req = 1'b0;
        repeat (30) tick();
        tests++; if (fault !== 1'b1 || powerdown !== 1'b0) begin fails++; $display("FAIL fault_sticky: got fault=%b pd=%b expected fault=1 pd=0", fault, powerdown); end
        lock = 1'b0; rst = 1'b1;
        tick();
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault_cleared_by_rst: got %b expected 0", fault); end
        $display("[TB] timeout: two timeouts led to FAULT, cleared by RST");
    endtask

    task automatic test_random();
        int       cycles;
        int       seg;
        int       len;
        int       fault_time;
        logic [13:0] got_v, exp_v;
        rst = 1'b1; lock = 1'b0; pd_req = 1'b0;
        tick();
        rst = 1'b0;
        cycles = 0; seg = 0; fault_time = 0;
        while (cycles < 4000 && fails < 20) begin
            len = $urandom_range(1, 40);
            rst = 1'b0;
            if (fault_time > 40 || $urandom_range(0, 63) == 0) begin
                rst = 1'b1; len = $urandom_range(1, 3); fault_time = 0;
            end
            pd_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) lock = ~lock;
            $display("[TB] seg %0d: rst=%b pd_req=%b lock=%b len=%0d", seg, rst, pd_req, lock, len);
            for (int i = 0; i < len; i++) begin
                tick();
                cycles++;
                exp_v = model_outputs();
                got_v = {powerdown, sys_rst, ready, fault, retry_cnt, loss_cnt};
                tests++;
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL random_cycle_%0d: got pd/sr/rdy/flt/retry/loss=%b expected %b", cycles, got_v, exp_v);
                end
                if (m_phase == M_FAULT) fault_time++;
            end
            seg++;
        end
        rst = 1'b0; pd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_chatter();
        test_lock_loss();
        test_pd_req();
        test_reset_mid_stable();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        fails++;
        $display("FAIL watchdog: got simulation still running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
